// File: rtl/gpr_wb_if.sv
// Writeback and issue-side signal bundle for the GPR write-port arbiter.
// The slave side is the arbiter. The master side is whatever drives ALU, load and issue traffic.
interface gpr_wb_if #(
  parameter int DATA_W = 32
);
  logic              alu_we;
  logic [4:0]        alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [4:0]        ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              iss_valid;
  logic              iss_is_load;
  logic [4:0]        iss_rs1;
  logic [4:0]        iss_rs2;
  logic [4:0]        iss_rd;
  logic              iss_stall;
  logic              gpr_we;
  logic [4:0]        gpr_rd;
  logic [DATA_W-1:0] gpr_rrd;
  logic [31:0]       pending;

  modport slave (
    input  alu_we, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  iss_valid, iss_is_load, iss_rs1, iss_rs2, iss_rd,
    output ld_ready, iss_stall, gpr_we, gpr_rd, gpr_rrd, pending
  );

  modport master (
    output alu_we, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output iss_valid, iss_is_load, iss_rs1, iss_rs2, iss_rd,
    input  ld_ready, iss_stall, gpr_we, gpr_rd, gpr_rrd, pending
  );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// Shares the single GPR write port between the ALU (never stalls) and buffered load writebacks.
// It also keeps the per-register load scoreboard that drives the issue stall.
module gpr_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  gpr_wb_if.slave  bus
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [AW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic [31:0]       pending_q, pending_nxt;
  logic [4:0]        rd_mem   [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

  logic alu_act, fifo_ne, sel_fifo, sel_direct, deq, direct, ld_fire, enq, iss_set;
  logic ld_commit;
  logic [4:0] commit_rd;

  assign alu_act    = bus.alu_we && (bus.alu_rd != 5'd0);
  assign fifo_ne    = (count != '0);
  assign sel_fifo   = !alu_act && fifo_ne;
  assign sel_direct = !alu_act && !fifo_ne && bus.ld_valid && (bus.ld_rd != 5'd0);
  assign deq        = rst && sel_fifo;
  assign direct     = rst && sel_direct;

  assign bus.ld_ready = rst && (count < FULL);
  assign ld_fire      = bus.ld_valid && bus.ld_ready;
  // Loads with rd==0 and direct-written loads are consumed without occupying a slot
  assign enq          = ld_fire && (bus.ld_rd != 5'd0) && !direct;

  // Write-port mux: combinational so the register file can forward in the same cycle
  always_comb begin
    bus.gpr_we  = 1'b0;
    bus.gpr_rd  = 5'd0;
    bus.gpr_rrd = '0;
    if (rst) begin
      if (alu_act) begin
        bus.gpr_we  = 1'b1;
        bus.gpr_rd  = bus.alu_rd;
        bus.gpr_rrd = bus.alu_data;
      end else if (sel_fifo) begin
        bus.gpr_we  = 1'b1;
        bus.gpr_rd  = rd_mem[head];
        bus.gpr_rrd = data_mem[head];
      end else if (sel_direct) begin
        bus.gpr_we  = 1'b1;
        bus.gpr_rd  = bus.ld_rd;
        bus.gpr_rrd = bus.ld_data;
      end
    end
  end

  assign ld_commit = deq || direct;
  assign commit_rd = deq ? rd_mem[head] : bus.ld_rd;

  assign bus.iss_stall = rst && bus.iss_valid &&
                         (((bus.iss_rs1 != 5'd0) && pending_q[bus.iss_rs1]) ||
                          ((bus.iss_rs2 != 5'd0) && pending_q[bus.iss_rs2]) ||
                          ((bus.iss_rd  != 5'd0) && pending_q[bus.iss_rd]));
  assign iss_set = bus.iss_valid && !bus.iss_stall && bus.iss_is_load && (bus.iss_rd != 5'd0);

  // A newly issued load to the same register outranks a commit clearing it
  always_comb begin
    pending_nxt = pending_q;
    if (ld_commit) pending_nxt[commit_rd] = 1'b0;
    if (iss_set)   pending_nxt[bus.iss_rd] = 1'b1;
  end

  assign bus.pending = pending_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      pending_q <= '0;
    end else begin
      if (enq) tail <= tail + AW'(1);
      if (deq) head <= head + AW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      pending_q <= pending_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      rd_mem[tail]   <= bus.ld_rd;
      data_mem[tail] <= bus.ld_data;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst && alu_act && pending_q[bus.alu_rd]) begin
      $display("bug: ALU write to x%0d while a load to it is outstanding (WAW)", bus.alu_rd);
      $finish;
    end
    if (rst && bus.ld_valid && (bus.ld_rd != 5'd0) && !pending_q[bus.ld_rd]) begin
      $display("bug: load writeback to x%0d without a scoreboard entry", bus.ld_rd);
      $finish;
    end
  end
`endif
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: reset, direct/buffered load writeback, FIFO full, hazards.
module tb_gpr_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gpr_wb_if #(.DATA_W(32)) bus ();
  gpr_wb_arbiter #(.DATA_W(32), .FIFO_DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  logic [37:0] wb;
  assign wb = {bus.gpr_we, bus.gpr_rd, bus.gpr_rrd};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    bus.alu_we = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'h0;
    bus.ld_valid = 1'b0; bus.ld_rd = 5'd0; bus.ld_data = 32'h0;
    bus.iss_valid = 1'b0; bus.iss_is_load = 1'b0;
    bus.iss_rs1 = 5'd0; bus.iss_rs2 = 5'd0; bus.iss_rd = 5'd0;
  endtask

  task automatic issue_load(input logic [4:0] r);
    bus.iss_valid = 1'b1; bus.iss_is_load = 1'b1; bus.iss_rd = r;
    bus.iss_rs1 = 5'd0; bus.iss_rs2 = 5'd0;
    mid;
    n_cmp++; if (bus.iss_stall !== 1'b0) begin n_err++; $display("FAIL issue_load_stall x%0d: got %b want 0", r, bus.iss_stall); end
    tick;
    bus.iss_valid = 1'b0; bus.iss_is_load = 1'b0; bus.iss_rd = 5'd0;
    n_cmp++; if (bus.pending[r] !== 1'b1) begin n_err++; $display("FAIL issue_load_pending x%0d: got %b want 1", r, bus.pending[r]); end
  endtask

  task automatic test_reset;
    idle_inputs;
    rst = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd6; bus.ld_data = 32'h66;
    bus.alu_we = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h55;
    bus.iss_valid = 1'b1; bus.iss_rs1 = 5'd6;
    tick;
    for (int i = 0; i < 2; i++) begin
      mid;
      n_cmp++; if (bus.ld_ready !== 1'b0) begin n_err++; $display("FAIL rst_ld_ready: got %b want 0", bus.ld_ready); end
      n_cmp++; if (wb !== 38'h0) begin n_err++; $display("FAIL rst_wb: got %h want 0", wb); end
      n_cmp++; if (bus.pending !== 32'h0) begin n_err++; $display("FAIL rst_pending: got %h want 0", bus.pending); end
      n_cmp++; if (bus.iss_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", bus.iss_stall); end
      tick;
    end
    idle_inputs;
    rst = 1'b1;
    mid;
    n_cmp++; if (bus.ld_ready !== 1'b1) begin n_err++; $display("FAIL rel_ld_ready: got %b want 1", bus.ld_ready); end
    n_cmp++; if (wb !== 38'h0) begin n_err++; $display("FAIL rel_wb: got %h want 0", wb); end
    tick;
  endtask

  task automatic test_uncontended;
    issue_load(5'd5);
    n_cmp++; if (bus.pending !== 32'h0000_0020) begin n_err++; $display("FAIL unc_pending_set: got %h want 00000020", bus.pending); end
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd5; bus.ld_data = 32'hDEADBEEF;
    mid;
    n_cmp++; if (wb !== {1'b1, 5'd5, 32'hDEADBEEF}) begin n_err++; $display("FAIL unc_wb: got %h want %h", wb, {1'b1, 5'd5, 32'hDEADBEEF}); end
    n_cmp++; if (bus.ld_ready !== 1'b1) begin n_err++; $display("FAIL unc_ld_ready: got %b want 1", bus.ld_ready); end
    tick;
    idle_inputs;
    n_cmp++; if (bus.pending !== 32'h0) begin n_err++; $display("FAIL unc_pending_clr: got %h want 0", bus.pending); end
    mid;
    n_cmp++; if (wb !== 38'h0) begin n_err++; $display("FAIL unc_idle_wb: got %h want 0", wb); end
    tick;
  endtask

  task automatic test_drops;
    bus.alu_we = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1234;
    mid;
    n_cmp++; if (wb !== 38'h0) begin n_err++; $display("FAIL drop_alu_x0: got %h want 0", wb); end
    tick;
    idle_inputs;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_data = 32'h5678;
    mid;
    n_cmp++; if (wb !== 38'h0) begin n_err++; $display("FAIL drop_ld_x0_wb: got %h want 0", wb); end
    n_cmp++; if (bus.ld_ready !== 1'b1) begin n_err++; $display("FAIL drop_ld_x0_ready: got %b want 1", bus.ld_ready); end
    tick;
    idle_inputs;
    mid;
    n_cmp++; if (wb !== 38'h0) begin n_err++; $display("FAIL drop_ld_x0_not_buffered: got %h want 0", wb); end
    tick;
  endtask

  task automatic test_collision;
    issue_load(5'd7);
    bus.alu_we = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h11;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h22;
    mid;
    n_cmp++; if (wb !== {1'b1, 5'd3, 32'h11}) begin n_err++; $display("FAIL col_alu_wb: got %h want %h", wb, {1'b1, 5'd3, 32'h11}); end
    n_cmp++; if (bus.ld_ready !== 1'b1) begin n_err++; $display("FAIL col_ld_ready: got %b want 1", bus.ld_ready); end
    tick;
    idle_inputs;
    mid;
    n_cmp++; if (wb !== {1'b1, 5'd7, 32'h22}) begin n_err++; $display("FAIL col_ld_wb: got %h want %h", wb, {1'b1, 5'd7, 32'h22}); end
    n_cmp++; if (bus.pending !== 32'h0000_0080) begin n_err++; $display("FAIL col_pending_hold: got %h want 00000080", bus.pending); end
    tick;
    mid;
    n_cmp++; if (wb !== 38'h0) begin n_err++; $display("FAIL col_drained_wb: got %h want 0", wb); end
    n_cmp++; if (bus.pending !== 32'h0) begin n_err++; $display("FAIL col_pending_clr: got %h want 0", bus.pending); end
    tick;
  endtask

  task automatic test_full_fifo;
    issue_load(5'd8);
    issue_load(5'd9);
    issue_load(5'd10);
    bus.alu_we = 1'b1; bus.alu_rd = 5'd11; bus.alu_data = 32'hA1;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd8; bus.ld_data = 32'h80;
    mid;
    n_cmp++; if (wb !== {1'b1, 5'd11, 32'hA1}) begin n_err++; $display("FAIL full_a_wb: got %h want %h", wb, {1'b1, 5'd11, 32'hA1}); end
    n_cmp++; if (bus.ld_ready !== 1'b1) begin n_err++; $display("FAIL full_a_ready: got %b want 1", bus.ld_ready); end
    tick;
    bus.alu_rd = 5'd12; bus.alu_data = 32'hA2; bus.ld_rd = 5'd9; bus.ld_data = 32'h90;
    mid;
    n_cmp++; if (bus.ld_ready !== 1'b1) begin n_err++; $display("FAIL full_b_ready: got %b want 1", bus.ld_ready); end
    tick;
    bus.alu_rd = 5'd13; bus.alu_data = 32'hA3; bus.ld_rd = 5'd10; bus.ld_data = 32'h100;
    mid;
    n_cmp++; if (bus.ld_ready !== 1'b0) begin n_err++; $display("FAIL full_c_ready: got %b want 0", bus.ld_ready); end
    n_cmp++; if (wb !== {1'b1, 5'd13, 32'hA3}) begin n_err++; $display("FAIL full_c_wb: got %h want %h", wb, {1'b1, 5'd13, 32'hA3}); end
    tick;
    bus.alu_we = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'h0;
    mid;
    n_cmp++; if (wb !== {1'b1, 5'd8, 32'h80}) begin n_err++; $display("FAIL full_d_wb: got %h want %h", wb, {1'b1, 5'd8, 32'h80}); end
    n_cmp++; if (bus.ld_ready !== 1'b0) begin n_err++; $display("FAIL full_d_ready: got %b want 0", bus.ld_ready); end
    n_cmp++; if (bus.pending !== 32'h0000_0700) begin n_err++; $display("FAIL full_d_pending: got %h want 00000700", bus.pending); end
    tick;
    mid;
    n_cmp++; if (wb !== {1'b1, 5'd9, 32'h90}) begin n_err++; $display("FAIL full_e_wb: got %h want %h", wb, {1'b1, 5'd9, 32'h90}); end
    n_cmp++; if (bus.ld_ready !== 1'b1) begin n_err++; $display("FAIL full_e_ready: got %b want 1", bus.ld_ready); end
    n_cmp++; if (bus.pending !== 32'h0000_0600) begin n_err++; $display("FAIL full_e_pending: got %h want 00000600", bus.pending); end
    tick;
    idle_inputs;
    mid;
    n_cmp++; if (wb !== {1'b1, 5'd10, 32'h100}) begin n_err++; $display("FAIL full_f_wb: got %h want %h", wb, {1'b1, 5'd10, 32'h100}); end
    tick;
    mid;
    n_cmp++; if (wb !== 38'h0) begin n_err++; $display("FAIL full_empty_wb: got %h want 0", wb); end
    n_cmp++; if (bus.pending !== 32'h0) begin n_err++; $display("FAIL full_pending_clr: got %h want 0", bus.pending); end
    tick;
  endtask

  task automatic test_hazard;
    issue_load(5'd4);
    bus.iss_valid = 1'b1; bus.iss_is_load = 1'b0; bus.iss_rs1 = 5'd4; bus.iss_rs2 = 5'd0; bus.iss_rd = 5'd15;
    for (int i = 0; i < 2; i++) begin
      mid;
      n_cmp++; if (bus.iss_stall !== 1'b1) begin n_err++; $display("FAIL haz_wait%0d: got %b want 1", i, bus.iss_stall); end
      tick;
    end
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd4; bus.ld_data = 32'h44;
    mid;
    n_cmp++; if (bus.iss_stall !== 1'b1) begin n_err++; $display("FAIL haz_commit_stall: got %b want 1", bus.iss_stall); end
    n_cmp++; if (wb !== {1'b1, 5'd4, 32'h44}) begin n_err++; $display("FAIL haz_commit_wb: got %h want %h", wb, {1'b1, 5'd4, 32'h44}); end
    tick;
    bus.ld_valid = 1'b0; bus.ld_rd = 5'd0;
    mid;
    n_cmp++; if (bus.iss_stall !== 1'b0) begin n_err++; $display("FAIL haz_released: got %b want 0", bus.iss_stall); end
    tick;
    idle_inputs;
    issue_load(5'd4);
    bus.iss_valid = 1'b1; bus.iss_rs1 = 5'd0; bus.iss_rs2 = 5'd0; bus.iss_rd = 5'd0;
    mid;
    n_cmp++; if (bus.iss_stall !== 1'b0) begin n_err++; $display("FAIL haz_x0_nostall: got %b want 0", bus.iss_stall); end
    tick;
    bus.iss_rs2 = 5'd4;
    mid;
    n_cmp++; if (bus.iss_stall !== 1'b1) begin n_err++; $display("FAIL haz_rs2_stall: got %b want 1", bus.iss_stall); end
    tick;
    bus.iss_rs2 = 5'd0; bus.iss_rd = 5'd4;
    mid;
    n_cmp++; if (bus.iss_stall !== 1'b1) begin n_err++; $display("FAIL haz_waw_stall: got %b want 1", bus.iss_stall); end
    tick;
    idle_inputs;
    bus.alu_we = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFF;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd4; bus.ld_data = 32'h4;
    mid;
    n_cmp++; if (wb !== {1'b1, 5'd4, 32'h4}) begin n_err++; $display("FAIL haz_alu_x0_ld_wb: got %h want %h", wb, {1'b1, 5'd4, 32'h4}); end
    tick;
    idle_inputs;
    n_cmp++; if (bus.pending !== 32'h0) begin n_err++; $display("FAIL haz_pending_clr: got %h want 0", bus.pending); end
  endtask

  task automatic test_reset_mid;
    issue_load(5'd20);
    issue_load(5'd21);
    bus.alu_we = 1'b1; bus.alu_rd = 5'd11; bus.alu_data = 32'hB1;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd20; bus.ld_data = 32'h200;
    tick;
    bus.alu_rd = 5'd12; bus.alu_data = 32'hB2; bus.ld_rd = 5'd21; bus.ld_data = 32'h210;
    tick;
    idle_inputs;
    rst = 1'b0;
    mid;
    n_cmp++; if (wb !== 38'h0) begin n_err++; $display("FAIL rmid_wb_in_reset: got %h want 0", wb); end
    n_cmp++; if (bus.ld_ready !== 1'b0) begin n_err++; $display("FAIL rmid_ready_in_reset: got %b want 0", bus.ld_ready); end
    tick;
    rst = 1'b1;
    mid;
    n_cmp++; if (wb !== 38'h0) begin n_err++; $display("FAIL rmid_wb_after: got %h want 0", wb); end
    n_cmp++; if (bus.pending !== 32'h0) begin n_err++; $display("FAIL rmid_pending: got %h want 0", bus.pending); end
    n_cmp++; if (bus.ld_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready_after: got %b want 1", bus.ld_ready); end
    tick;
    mid;
    n_cmp++; if (wb !== 38'h0) begin n_err++; $display("FAIL rmid_wb_later: got %h want 0", wb); end
    tick;
  endtask

  initial begin
    idle_inputs;
    test_reset;
    test_uncontended;
    test_drops;
    test_collision;
    test_full_fifo;
    test_hazard;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Owns the single write port of the 32x32 GPR file and shares it between two writeback sources: the ALU (fixed priority, cannot stall) and the load unit (valid/ready handshake, buffered in a small in-order FIFO).
- Also holds the load scoreboard, one pending bit per register, and generates the issue-stage stall for RAW and WAW hazards on outstanding loads.
- Sits between execute/memory writeback and the GPR write port (we, rd, rrd).

Parameters:
- FIFO_DEPTH, 2, load-writeback buffer entries. Power of two, >=2.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-low (rst==0 resets)
- alu_we  in  1  ALU writeback valid
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- ld_valid  in  1  load writeback valid
- ld_ready  out  1  load writeback accepted
- ld_rd  in  5  load destination register
- ld_data  in  32  load data
- iss_valid  in  1  instruction presented at issue
- iss_is_load  in  1  presented instruction is a load
- iss_rs1  in  5  source register 1
- iss_rs2  in  5  source register 2
- iss_rd  in  5  destination register
- iss_stall  out  1  hold issue this cycle
- gpr_we  out  1  GPR write enable
- gpr_rd  out  5  GPR write address
- gpr_rrd  out  32  GPR write data
- pending  out  32  scoreboard bitmap (debug/verification)

Behaviour:
- Reset (rst==0 at an edge): FIFO emptied, pending=0.
  - While rst==0 the outputs are forced: gpr_we=0, ld_ready=0, iss_stall=0, gpr_rd=0, gpr_rrd=0.
  - Reset mid-operation discards buffered loads without writing them.
- alu_act = alu_we && alu_rd!=0. An ALU write with rd==0 is dropped.
- Write-port mux is combinational, with zero added latency so GPR same-cycle forwarding still works. Priority:
  1. alu_act: gpr_rd=alu_rd, gpr_rrd=alu_data.
  2. Else, FIFO non-empty: the FIFO head is written and dequeued at the edge.
  3. Else, ld_valid && ld_rd!=0: direct write of ld_rd/ld_data, not enqueued.
  4. Else gpr_we=0 and gpr_rd/gpr_rrd=0.
- gpr_we is never 1 with gpr_rd==0.
- ld_ready = rst && (count<FIFO_DEPTH). It depends on the registered count only; there is no same-cycle pass-through when full.
- Load beat fires when ld_valid && ld_ready:
  - ld_rd==0: consumed and dropped.
  - Direct-written (case 3): consumed.
  - Otherwise: enqueued at the tail. Enqueue and dequeue in the same cycle leave count unchanged.
- Load writes commit in acceptance order. The ALU never waits.
- Scoreboard:
  - Set pending[iss_rd] at the edge when iss_valid && !iss_stall && iss_is_load && iss_rd!=0.
  - Clear pending[r] at the edge when a load-sourced write to r commits (case 2 or 3).
  - If set and clear hit the same register in one cycle, set wins.
- iss_stall = iss_valid && ((iss_rs1!=0 && pending[iss_rs1]) || (iss_rs2!=0 && pending[iss_rs2]) || (iss_rd!=0 && pending[iss_rd])).
  - Uses registered pending only, so a same-cycle commit still stalls. The penalty is exactly one cycle after the commit.
- Simulation checks, each of which $display's a "bug:" message and calls $finish:
  - alu_act while pending[alu_rd]==1 (WAW violation).
  - ld_valid with ld_rd!=0 while pending[ld_rd]==0 (unscoreboarded load).

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles with ld_valid=1 -> ld_ready=0, gpr_we=0, pending=0. After release -> ld_ready=1.
- Uncontended load: issue load rd=5 (pending[5]=1). Next cycle ld_valid, ld_rd=5, data=0xDEADBEEF -> same cycle gpr_we=1, gpr_rd=5; pending[5]=0 after the edge.
- Collision: ALU writes x3=0x11 while load x7=0x22 arrives -> ALU writes x3; load enqueued (count=1); x7 written the next cycle.
- Full FIFO: ALU writes every cycle for 3 cycles with loads x8, x9, x10 offered -> two accepted, ld_ready=0 on the third. When the ALU goes idle, x8 then x9 are written in consecutive cycles; then x10 is accepted.
- Hazard: pending[4]=1, issue add rs1=4 -> iss_stall=1 until one cycle after x4 commits. rs1=0 with pending[0] never stalls.
- Reset mid-operation: FIFO holding 2 entries, pulse rst=0 for 1 cycle -> no GPR write of buffered data, pending=0, count=0.
